// File: rtl/mem_arbiter_pkg.sv
// Shared types for the fetch/data memory arbiter.
// Holds the FSM states, requester ids and watchdog sizing.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_BUSY,
    ARB_RECOVER
  } arb_state_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_t;

  // Watchdog counter width; a disabled watchdog still needs one bit.
  function automatic int cnt_width(int t);
    return (t > 0) ? $clog2(t + 1) : 1;
  endfunction

endpackage

// File: rtl/arb_rr2.sv
// Two-way requester pick: fixed data priority or
// round-robin against the previous grant.
module arb_rr2
  import mem_arbiter_pkg::*;
#(
  parameter int DATA_PRIORITY = 0
) (
  input  logic    req_i,
  input  logic    req_d,
  input  req_id_t last_grant,
  output logic    valid,
  output req_id_t grant
);

  always_comb begin
    valid = req_i | req_d;
    grant = REQ_I;
    unique case (1'b1)
      req_i & req_d:
        grant = (DATA_PRIORITY != 0) ? REQ_D :
                (last_grant == REQ_D) ? REQ_I : REQ_D;
      req_d & ~req_i:
        grant = REQ_D;
      default:
        grant = REQ_I;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between fetch and load/store,
// with a registered port, rdata capture and a watchdog.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int DATA_PRIORITY  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_resp,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [3:0]        d_wmask,
  output logic              d_resp,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_wmask,
  input  logic              mem_resp,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              timeout_err
);

  localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  arb_state_t        state;
  arb_state_t        state_nx;
  req_id_t           grant;
  req_id_t           last_grant;
  req_id_t           pick;
  logic              pick_vld;
  logic [CNT_W-1:0]  wd_cnt;
  logic [DATA_W-1:0] cap;
  logic [DATA_W-1:0] rdata;
  logic              done;
  logic              expire;
  logic              finish;

  arb_rr2 #(
    .DATA_PRIORITY(DATA_PRIORITY)
  ) u_rr (
    .req_i     (i_read),
    .req_d     (d_read | d_write),
    .last_grant(last_grant),
    .valid     (pick_vld),
    .grant     (pick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ARB_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    done   = (state == ARB_BUSY) && mem_resp;
    expire = (TIMEOUT_CYCLES != 0) &&
             (state == ARB_BUSY) && !mem_resp &&
             (wd_cnt == CNT_LAST);
    finish = done || expire;

    // Completion data bypasses the capture register.
    rdata = done   ? mem_rdata :
            expire ? '0 : cap;

    i_resp      = finish && (grant == REQ_I);
    d_resp      = finish && (grant == REQ_D);
    i_rdata     = rdata;
    d_rdata     = rdata;
    timeout_err = expire;
    busy        = (state != ARB_IDLE);

    state_nx = state;
    unique case (state)
      ARB_IDLE:    if (pick_vld) state_nx = ARB_BUSY;
      ARB_BUSY:    if (finish)   state_nx = ARB_RECOVER;
      ARB_RECOVER: state_nx = ARB_IDLE;
      default:     state_nx = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wmask  <= 4'h0;
      cap        <= '0;
      wd_cnt     <= '0;
      grant      <= REQ_I;
      last_grant <= REQ_D;
    end else begin
      unique case (state)
        ARB_IDLE: if (pick_vld) begin
          grant      <= pick;
          last_grant <= pick;
          wd_cnt     <= '0;
          if (pick == REQ_D) begin
            // A simultaneous read+write is issued as the write.
            mem_read  <= d_read & ~d_write;
            mem_write <= d_write;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            mem_wmask <= d_wmask;
          end else begin
            mem_read  <= 1'b1;
            mem_write <= 1'b0;
            mem_addr  <= i_addr;
            mem_wdata <= '0;
            mem_wmask <= 4'h0;
          end
        end
        ARB_BUSY: begin
          if (finish) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            cap       <= done ? mem_rdata : '0;
          end else if (wd_cnt != CNT_MAX) begin
            wd_cnt <= wd_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: round-robin and data-priority
// instances on shared stimulus, checked against a txn model.
module tb_mem_arbiter;

  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        i_read = 1'b0;
  logic [31:0] i_addr = '0;
  logic        d_read = 1'b0;
  logic        d_write = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [3:0]  d_wmask = '0;
  logic        mem_resp = 1'b0;
  logic [31:0] mem_rdata = '0;

  logic [1:0]  i_resp, d_resp, mem_read, mem_write;
  logic [1:0]  busy, terr;
  logic [31:0] i_rdata[2], d_rdata[2];
  logic [31:0] mem_addr[2], mem_wdata[2];
  logic [3:0]  mem_wmask[2];

  int errs = 0;
  int checks = 0;

  mem_arbiter #(
    .ADDR_W(32), .DATA_W(32),
    .TIMEOUT_CYCLES(TO), .DATA_PRIORITY(0)
  ) u0 (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_addr(i_addr),
    .i_resp(i_resp[0]), .i_rdata(i_rdata[0]),
    .d_read(d_read), .d_write(d_write),
    .d_addr(d_addr), .d_wdata(d_wdata),
    .d_wmask(d_wmask),
    .d_resp(d_resp[0]), .d_rdata(d_rdata[0]),
    .mem_read(mem_read[0]), .mem_write(mem_write[0]),
    .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .mem_wmask(mem_wmask[0]),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata),
    .busy(busy[0]), .timeout_err(terr[0])
  );

  mem_arbiter #(
    .ADDR_W(32), .DATA_W(32),
    .TIMEOUT_CYCLES(TO), .DATA_PRIORITY(1)
  ) u1 (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_addr(i_addr),
    .i_resp(i_resp[1]), .i_rdata(i_rdata[1]),
    .d_read(d_read), .d_write(d_write),
    .d_addr(d_addr), .d_wdata(d_wdata),
    .d_wmask(d_wmask),
    .d_resp(d_resp[1]), .d_rdata(d_rdata[1]),
    .mem_read(mem_read[1]), .mem_write(mem_write[1]),
    .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .mem_wmask(mem_wmask[1]),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata),
    .busy(busy[1]), .timeout_err(terr[1])
  );

  // Transaction-level view: one txn in flight or a cooldown.
  typedef struct {
    bit          act;
    bit          cool;
    bit          own;
    bit          last;
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] held;
    logic [3:0]  wmask;
    int          age;
  } mdl_t;

  typedef struct {
    bit          ir, dr, rd, wr, bz, te;
    logic [31:0] ird, drd, ad, wd;
    logic [3:0]  wm;
  } exp_t;

  mdl_t m[2];

  function automatic mdl_t mreset();
    mdl_t r;
    r.act = 0; r.cool = 0; r.own = 0; r.last = 1;
    r.rd = 0; r.wr = 0; r.addr = '0; r.wdata = '0;
    r.held = '0; r.wmask = '0; r.age = 0;
    return r;
  endfunction

  function automatic exp_t mexp(mdl_t s);
    exp_t e;
    bit ok, to;
    ok = s.act && mem_resp;
    to = s.act && !mem_resp && (s.age + 1 == TO);
    e.ir = (ok || to) && !s.own;
    e.dr = (ok || to) && s.own;
    e.te = to;
    e.rd = s.act && s.rd;
    e.wr = s.act && s.wr;
    e.bz = s.act || s.cool;
    e.ird = ok ? mem_rdata : to ? 32'h0 : s.held;
    e.drd = e.ird;
    e.ad = s.addr;
    e.wd = s.wdata;
    e.wm = s.wmask;
    return e;
  endfunction

  function automatic mdl_t mstep(mdl_t s, bit prio);
    mdl_t n = s;
    bit ok, to, ai, ad, win;
    if (s.act) begin
      ok = mem_resp;
      to = !mem_resp && (s.age + 1 == TO);
      if (ok || to) begin
        n.act = 0; n.cool = 1;
        n.held = ok ? mem_rdata : 32'h0;
      end else begin
        n.age = s.age + 1;
      end
    end else if (s.cool) begin
      n.cool = 0;
    end else begin
      ai = i_read;
      ad = d_read || d_write;
      if (ai || ad) begin
        win = (ai && ad) ? (prio ? 1'b1 : !s.last) : ad;
        n.act = 1; n.age = 0; n.own = win; n.last = win;
        if (win) begin
          n.wr = d_write; n.rd = d_read && !d_write;
          n.addr = d_addr; n.wdata = d_wdata;
          n.wmask = d_wmask;
        end else begin
          n.rd = 1; n.wr = 0; n.addr = i_addr;
          n.wdata = '0; n.wmask = '0;
        end
      end
    end
    return n;
  endfunction

  function automatic void chk(string n, int k,
                              logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL u%0d.%s: got %h want %h", k, n, a, e);
    end
  endfunction

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      exp_t e;
      if (!rst_n) m[k] = mreset();
      e = mexp(m[k]);
      chk("i_resp", k, i_resp[k], e.ir);
      chk("d_resp", k, d_resp[k], e.dr);
      chk("mem_read", k, mem_read[k], e.rd);
      chk("mem_write", k, mem_write[k], e.wr);
      chk("busy", k, busy[k], e.bz);
      chk("timeout_err", k, terr[k], e.te);
      chk("i_rdata", k, i_rdata[k], e.ird);
      chk("d_rdata", k, d_rdata[k], e.drd);
      chk("mem_addr", k, mem_addr[k], e.ad);
      chk("mem_wdata", k, mem_wdata[k], e.wd);
      chk("mem_wmask", k, mem_wmask[k], e.wm);
      if (rst_n) m[k] = mstep(m[k], k == 1);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    i_read = 0; d_read = 0; d_write = 0; mem_resp = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle_in();
    step();
    step();
    rst_n = 1;
  endtask

  initial begin
    #1 rst_n = 0;
    step();
    chk("rst_mem_read", 0, mem_read[0], 0);
    chk("rst_busy", 0, busy[0], 0);
    chk("rst_addr", 0, mem_addr[0], 0);
    do_reset();

    // Fetch only, memory answers two cycles after the strobe.
    i_read = 1; i_addr = 32'h100;
    step();
    #1;
    chk("f_mem_read", 0, mem_read[0], 1);
    chk("f_mem_addr", 0, mem_addr[0], 32'h100);
    step();
    step();
    mem_resp = 1; mem_rdata = 32'hDEADBEEF;
    #1;
    chk("f_i_resp", 0, i_resp[0], 1);
    chk("f_d_resp", 0, d_resp[0], 0);
    chk("f_bypass", 0, i_rdata[0], 32'hDEADBEEF);
    step();
    mem_resp = 0; mem_rdata = 32'h0BADF00D;
    #1;
    chk("f_hold", 0, i_rdata[0], 32'hDEADBEEF);
    chk("f_rec_read", 0, mem_read[0], 0);
    chk("f_rec_busy", 0, busy[0], 1);
    step();
    i_read = 0;
    step();
    chk("f_no_reissue", 0, mem_read[0], 0);
    chk("f_idle", 0, busy[0], 0);

    // Constant tie: u0 alternates, u1 always serves data.
    do_reset();
    i_read = 1; i_addr = 32'h200;
    d_write = 1; d_addr = 32'h400;
    d_wdata = 32'h12345678; d_wmask = 4'hF;
    mem_resp = 1; mem_rdata = 32'h55;
    step();
    chk("t1_u0_read", 0, mem_read[0], 1);
    chk("t1_u0_addr", 0, mem_addr[0], 32'h200);
    chk("t1_u1_write", 1, mem_write[1], 1);
    chk("t1_u1_addr", 1, mem_addr[1], 32'h400);
    repeat (3) step();
    chk("t2_u0_write", 0, mem_write[0], 1);
    chk("t2_u0_read", 0, mem_read[0], 0);
    chk("t2_u0_wdata", 0, mem_wdata[0], 32'h12345678);
    chk("t2_u0_wmask", 0, mem_wmask[0], 4'hF);
    chk("t2_u1_write", 1, mem_write[1], 1);
    repeat (3) step();
    chk("t3_u0_read", 0, mem_read[0], 1);
    chk("t3_u0_addr", 0, mem_addr[0], 32'h200);
    chk("t3_u1_write", 1, mem_write[1], 1);
    idle_in();
    step();
    step();

    // Memory never answers a load: watchdog fires.
    do_reset();
    d_read = 1; d_addr = 32'h80; mem_rdata = 32'hAAAA5555;
    step();
    i_read = 1; i_addr = 32'h300;
    step();
    step();
    chk("w_no_early", 0, terr[0], 0);
    step();
    chk("w_terr", 0, terr[0], 1);
    chk("w_d_resp", 0, d_resp[0], 1);
    chk("w_d_rdata", 0, d_rdata[0], 0);
    chk("w_i_resp", 0, i_resp[0], 0);
    step();
    d_read = 0;
    chk("w_terr_pulse", 0, terr[0], 0);
    chk("w_rdata_hold", 0, d_rdata[0], 0);
    step();
    step();
    mem_resp = 1; mem_rdata = 32'h600D;
    #1;
    chk("w_next_read", 0, mem_read[0], 1);
    chk("w_next_addr", 0, mem_addr[0], 32'h300);
    chk("w_next_resp", 0, i_resp[0], 1);
    step();
    i_read = 0; mem_resp = 0;
    step();

    // Reset while a fetch is in flight.
    i_read = 1; i_addr = 32'h500;
    step();
    chk("r_busy_read", 0, mem_read[0], 1);
    rst_n = 0;
    mem_resp = 1;
    #1;
    chk("r_read_drop", 0, mem_read[0], 0);
    chk("r_addr_drop", 0, mem_addr[0], 0);
    chk("r_no_resp", 0, i_resp[0], 0);
    chk("r_busy_drop", 0, busy[0], 0);
    step();
    rst_n = 1;
    step();
    chk("r_refetch", 0, mem_read[0], 1);
    chk("r_refetch_resp", 0, i_resp[0], 1);
    chk("r_refetch_addr", 0, mem_addr[0], 32'h500);
    step();
    idle_in();
    step();

    // Random traffic, occasional async reset pulses.
    repeat (3000) begin
      step();
      i_read = $urandom_range(0, 9) < 6;
      d_read = $urandom_range(0, 9) < 4;
      d_write = $urandom_range(0, 9) < 3;
      i_addr = $urandom;
      d_addr = $urandom;
      d_wdata = $urandom;
      d_wmask = 4'($urandom);
      mem_resp = $urandom_range(0, 9) < 3;
      mem_rdata = $urandom;
      rst_n = $urandom_range(0, 499) != 0;
    end
    rst_n = 1;
    idle_in();
    step();
    step();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
